booth_multiplier: RTL

//  Multi-cycle signed 32x32 multiplier for the ALU mult path. Radix-2 Booth,
//  one add/subtract per cycle through one cla_adder instance.

---
 rtl/booth_multiplier.sv | 128 ++++++++++++
 1 files changed

// File: rtl/booth_multiplier.sv
// Radix-2 Booth signed 32x32 multiplier, one add per cycle through cla_adder.
// Returns the low product word plus a flag when the product overflows 32 bits.
module cla_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    input  logic [31:0] p,
    input  logic [31:0] g,
    output logic [31:0] s
);
    logic [32:0] c;

    // 4-bit lookahead groups; group carries ripple between groups
    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign s = p ^ c[31:0] ^ (a ^ b ^ p);
endmodule

module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] m;
    logic [64:0] prod;
    logic [4:0]  count;

    logic [31:0] op_a, op_b, sum;
    logic        c_in, ovf, sign;
    logic [64:0] prod_next;
    logic        last;

    always_comb begin
        op_a = prod[64:33];
        op_b = '0;
        c_in = 1'b0;
        unique case (prod[1:0])
            2'b01: op_b = m;
            2'b10: begin
                op_b = ~m;
                c_in = 1'b1;
            end
            default: op_b = '0;
        endcase
    end

    cla_adder u_add (
        .a    (op_a),
        .b    (op_b),
        .c_in (c_in),
        .p    (op_a ^ op_b),
        .g    (op_a & op_b),
        .s    (sum)
    );

    // Overflow-corrected sign keeps the shift exact even for M = 0x80000000
    assign ovf  = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
    assign sign = sum[31] ^ ovf;
    assign prod_next = {sign, sum, prod[32:1]};
    assign last = (count == 5'd31);

    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = BUSY;
        end else begin
            unique case (state)
                BUSY:    state_next = last ? DONE : BUSY;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            m              <= '0;
            prod           <= '0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_next;
            if (ctrl_MULT) begin
                m              <= data_operandA;
                prod           <= {32'd0, data_operandB, 1'b0};
                count          <= '0;
                data_result    <= '0;
                data_exception <= 1'b0;
            end else if (state == BUSY) begin
                prod  <= prod_next;
                count <= count + 5'd1;
                if (last) begin
                    data_result    <= prod_next[32:1];
                    data_exception <= prod_next[64:33] != {32{prod_next[32]}};
                end
            end
        end
    end

    assign data_resultRDY = (state == DONE);
endmodule
